// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit unsigned adder controller.
// One full-add slice (two half_adder instances plus an OR gate) is reused
// over WIDTH RUN cycles, LSB first, behind a start/busy/done handshake.
//
// Optional feature macro: SERIAL_ADD_OVF_EN (adds the registered ovf output).
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - request a new addition, accepted only in IDLE
//   a, b  - operands, sampled on the accepting edge only
//   busy  - high while the slice is iterating (WIDTH cycles)
//   done  - one-cycle pulse when sum/cout become valid
//   sum   - result of the last completed add, held until the next one
//   cout  - carry-out of the last completed add, held like sum
//   ovf   - (SERIAL_ADD_OVF_EN only) signed overflow of the last add

// 1-bit half adder used twice by the serial slice.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    // Partial sum keeps only WIDTH-1 bits; the newest bit comes straight
    // from the slice on the final edge.
    localparam int unsigned PS_W  = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic               busy_d;
    logic               done_d;

    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [PS_W-1:0]    ps;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               s1_c;
    logic               c1_c;
    logic               s_c;
    logic               c2_c;
    logic               co_c;
    logic               last_bit_c;
    logic [WIDTH-1:0]   ps_cat_c;

    // Full-add slice: two half adders and an OR for the carry.
    half_adder u_ha0 (
        .x (sa[0]),
        .y (sb[0]),
        .s (s1_c),
        .c (c1_c)
    );

    half_adder u_ha1 (
        .x (s1_c),
        .y (carry),
        .s (s_c),
        .c (c2_c)
    );

    assign co_c       = c1_c | c2_c;
    assign last_bit_c = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign ps_cat_c   = {s_c, ps};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so the registered
    // copies line up exactly with the state they describe.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == S_RUN)  busy_d = 1'b1;
        if (state_d == S_DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    // Operand shifters, carry, bit counter and held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if ((state == S_IDLE) && start) begin
            sa    <= a;
            sb    <= b;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            ps    <= PS_W'(ps_cat_c >> 1);
            carry <= co_c;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit_c) begin
                sum  <= ps_cat_c;
                cout <= co_c;
`ifdef SERIAL_ADD_OVF_EN
                // Carry into the MSB differs from carry out of it.
                ovf  <= carry ^ co_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed vectors
// plus randomized operations compared against a plain-arithmetic model.
module tb_serial_adder_ctrl;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned PERIOD = WIDTH + 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
    logic             exp_ovf;
`endif

    // Model state: last completed result as the DUT should hold it.
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;

    int n_checks;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One full operation: accept, WIDTH busy cycles, one done cycle, idle.
    task automatic run_op(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                          input bit hold, input bit scramble);
        logic [WIDTH:0] full;
        full = {1'b0, a_in} + {1'b0, b_in};
        @(negedge clk);
        a     = a_in;
        b     = b_in;
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= int'(WIDTH); i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (!hold) start = 1'b0;
                if (scramble) begin
                    a = WIDTH'($urandom);
                    b = WIDTH'($urandom);
                end
            end
            check("run_busy", 64'(busy), 64'(1'b1));
            check("run_done", 64'(done), 64'(1'b0));
            check("run_sum_held", 64'(sum), 64'(exp_sum));
            check("run_cout_held", 64'(cout), 64'(exp_cout));
        end
        exp_sum  = full[WIDTH-1:0];
        exp_cout = full[WIDTH];
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(1'b1));
        check("done_busy", 64'(busy), 64'(1'b0));
        check("done_sum", 64'(sum), 64'(exp_sum));
        check("done_cout", 64'(cout), 64'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (exp_sum[WIDTH-1] != a_in[WIDTH-1]);
        check("done_ovf", 64'(ovf), 64'(exp_ovf));
`endif
        @(negedge clk);
        start = 1'b0;
        check("idle_done", 64'(done), 64'(1'b0));
        check("idle_busy", 64'(busy), 64'(1'b0));
        check("idle_sum", 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        exp_sum  = '0;
        exp_cout = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf  = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(1'b0));
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'(1'b0));
`endif
        rst = 1'b0;

        // Directed vectors.
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        // Operands changed the cycle after acceptance must not matter.
        @(negedge clk);
        a = 8'h5A; b = 8'hA5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'h00; b = 8'h00;
        check("latch_busy", 64'(busy), 64'(1'b1));
        repeat (WIDTH) @(negedge clk);
        check("latch_done", 64'(done), 64'(1'b1));
        check("latch_sum", 64'(sum), 64'(8'hFF));
        check("latch_cout", 64'(cout), 64'(1'b0));
        exp_sum = 8'hFF; exp_cout = 1'b0;
        @(negedge clk);

        // start held high: one operation every WIDTH+2 edges.
        a = 8'h10; b = 8'h20; start = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_busy", 64'(busy), 64'((e % PERIOD) < WIDTH));
            check("hold_done", 64'(done), 64'((e % PERIOD) == WIDTH));
            if ((e % PERIOD) == WIDTH) check("hold_sum", 64'(sum), 64'(8'h30));
        end
        start = 1'b0;
        exp_sum = 8'h30; exp_cout = 1'b0;

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_done", 64'(done), 64'(1'b0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(cout), 64'(1'b0));
        exp_sum = '0; exp_cout = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(PERIOD); i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'(1'b0));
        end
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);

        // Signed-overflow vectors (ovf checked only when the feature exists).
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h40, 8'h20, 1'b0, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder controller: sequences a single 1-bit full-add slice (two half_adder instances plus an OR gate) over WIDTH clock cycles, LSB first.
- Provides a start/busy/done handshake, operand shift registers, a carry flip-flop, a bit counter and a held result register.
- Used wherever an N-bit add is required at minimum area and latency is not critical.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a new addition; accepted only in IDLE.
- a, input, WIDTH, operand A; sampled on the accepting edge only.
- b, input, WIDTH, operand B; sampled on the accepting edge only.
- busy, output, 1, high while in RUN.
- done, output, 1, one-cycle pulse when the result becomes valid.
- sum, output, WIDTH, result of the last completed operation; held until the next completion.
- cout, output, 1, carry-out of the last completed operation; held like sum.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flip-flop and counter cleared.
- States: IDLE, RUN, DONE. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - start=1 on an edge: load sa<=a, sb<=b, ps<=0, carry<=0, cnt<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Slice computes {c1,s1}=HA(sa[0],sb[0]), {c2,s}=HA(s1,carry), co=c1|c2.
  - Update: ps<={s,ps[WIDTH-1:1]}; sa, sb shift right by 1 (zero fill); carry<=co; cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge: sum<={s,ps[WIDTH-1:1]}, cout<=co, go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- busy=1 exactly while state==RUN (WIDTH cycles).
- Latency: the start-sampling edge is edge 0; done is high between edge WIDTH and edge WIDTH+1.
- Throughput with start held high: one operation every WIDTH+2 cycles.
- Operand changes after the accepting edge have no effect on the operation in progress.
- sum and cout change only on the completion edge or on reset; they are stable while busy.
- Arithmetic: unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b.
- Counter width: $clog2(WIDTH); wrap never reached, because the FSM leaves RUN at WIDTH-1.
- Reset asserted mid-RUN: the operation is aborted, no done pulse, sum/cout return to 0.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, registered), signed two's-complement overflow of the last completed operation.
  - On the final RUN edge: ovf<=carry_in_to_msb ^ co, where carry_in_to_msb is the carry flip-flop value used in that edge.
  - Held like sum; reset value 0.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, rst pulse, then start with a=0x00, b=0x00 -> busy high 8 cycles; done pulse after edge 8; sum=0x00, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1, done one cycle only; busy low in the done cycle.
- a=0x5A, b=0xA5, with a/b changed to 0x00 one cycle after start -> sum=0xFF, cout=0 (operands latched).
- start held high for 30 cycles, a=0x10, b=0x20 -> done pulses at edges 8, 18, 28; sum=0x30 each; start ignored while busy/done.
- start a=0x0F, b=0x01, assert rst after edge 3 of RUN -> busy=0, done never pulses, sum=0x00, cout=0; the next start completes normally.
- With SERIAL_ADD_OVF_EN: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x40+0x20 -> ovf=0.
